// File: rtl/dlst_meas.sv
// dlst_meas: measures the delay, in clk_dlst cycles, between a trigger pulse
// and the pulse that returns from a delay/stretch path. Reports the interval,
// a completion strobe, a timeout strobe, sticky protocol-error flags and a
// wrapping count of successful measurements.
module dlst_meas #(
  parameter int unsigned CNT_W   = 37,
  parameter int unsigned TIMEOUT = 200000000,
  parameter bit          SYNC_EN = 1'b1,
  parameter int unsigned NM_W    = 16
) (
  input  logic             clk_dlst,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  output logic             busy,
  output logic [CNT_W-1:0] meas,
  output logic             valid,
  output logic             tout,
  output logic             err_ovl,
  output logic             err_stray,
  output logic [NM_W-1:0]  n_meas
);

  // Interval limit expressed at counter width.
  localparam logic [CNT_W-1:0] TOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Rising edge of a level: high now, low on the previous cycle.
  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  logic             st_s;
  logic             sp_s;
  logic             st_d_r;
  logic             sp_d_r;
  logic             st_e_s;
  logic             sp_e_s;
  logic [NM_W-1:0]  n_base_s;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  // Both inputs see exactly the same path, so synchroniser latency cancels
  // out of the measured interval.
  generate
    if (SYNC_EN) begin : g_sync
      logic [1:0] st_sync_r;
      logic [1:0] sp_sync_r;

      // Two-flop synchronisers for start and stop.
      always_ff @(posedge clk_dlst or posedge rst) begin
        if (rst) begin
          st_sync_r <= 2'b00;
          sp_sync_r <= 2'b00;
        end else begin
          st_sync_r <= {st_sync_r[0], start};
          sp_sync_r <= {sp_sync_r[0], stop};
        end
      end

      assign st_s = st_sync_r[1];
      assign sp_s = sp_sync_r[1];
    end else begin : g_direct
      assign st_s = start;
      assign sp_s = stop;
    end
  endgenerate

  // Delayed copies of the (synchronised) inputs for edge detection.
  always_ff @(posedge clk_dlst or posedge rst) begin
    if (rst) begin
      st_d_r <= 1'b0;
      sp_d_r <= 1'b0;
    end else begin
      st_d_r <= st_s;
      sp_d_r <= sp_s;
    end
  end

  assign st_e_s = rise(st_s, st_d_r);
  assign sp_e_s = rise(sp_s, sp_d_r);

  // A clear coinciding with a success still leaves that success counted.
  assign n_base_s = clr ? {NM_W{1'b0}} : n_meas;

  // Measurement FSM with all outputs registered; strobes default low so
  // valid/tout can never last two cycles.
  always_ff @(posedge clk_dlst or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      meas      <= {CNT_W{1'b0}};
      valid     <= 1'b0;
      tout      <= 1'b0;
      busy      <= 1'b0;
      err_ovl   <= 1'b0;
      err_stray <= 1'b0;
      n_meas    <= {NM_W{1'b0}};
    end else begin
      valid <= 1'b0;
      tout  <= 1'b0;
      if (clr) begin
        err_ovl   <= 1'b0;
        err_stray <= 1'b0;
        n_meas    <= {NM_W{1'b0}};
      end else begin
        n_meas <= n_meas;
      end
      case (state_r)
        IDLE: begin
          if (st_e_s) begin
            // Start wins over a coincident stop; that stop is not stray.
            state_r <= RUN;
            cnt_r   <= CNT_W'(1);
            busy    <= 1'b1;
          end else if (sp_e_s) begin
            err_stray <= 1'b1;
          end else begin
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          if (st_e_s) begin
            // Re-trigger while busy is flagged but does not restart timing.
            err_ovl <= 1'b1;
          end else begin
            err_ovl <= clr ? 1'b0 : err_ovl;
          end
          if (sp_e_s) begin
            // A stop in the very cycle the limit is reached is a success.
            meas    <= cnt_r;
            valid   <= 1'b1;
            n_meas  <= n_base_s + NM_W'(1);
            state_r <= IDLE;
            busy    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r >= TOUT_C) begin
            tout    <= 1'b1;
            state_r <= IDLE;
            busy    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlst_meas.sv
// Self-checking bench for dlst_meas. A timestamp-based reference model works
// on the input pins; its per-cycle results are compared against the DUT a
// fixed pipeline depth (synchroniser + edge detect + output register) later.
module tb_dlst_meas;

  localparam int CNT_W   = 37;
  localparam int TIMEOUT = 120;
  localparam int NM_W    = 4;
  localparam int LAT     = 3;

  logic             clk_dlst = 1'b0;
  logic             rst      = 1'b1;
  logic             start    = 1'b0;
  logic             stop     = 1'b0;
  logic             clr      = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] meas;
  logic             valid;
  logic             tout;
  logic             err_ovl;
  logic             err_stray;
  logic [NM_W-1:0]  n_meas;

  always #5 clk_dlst = ~clk_dlst;

  dlst_meas #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .SYNC_EN(1'b1),
    .NM_W   (NM_W)
  ) dut (
    .clk_dlst (clk_dlst),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clr      (clr),
    .busy     (busy),
    .meas     (meas),
    .valid    (valid),
    .tout     (tout),
    .err_ovl  (err_ovl),
    .err_stray(err_stray),
    .n_meas   (n_meas)
  );

  typedef struct {
    logic             busy;
    logic [CNT_W-1:0] meas;
    logic             valid;
    logic             tout;
    logic             ovl;
    logic             stray;
    logic [NM_W-1:0]  n;
  } snap_t;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  // Reference model state: open measurement with its start timestamp.
  bit               m_open;
  int               m_t;
  int               m_t0;
  logic [CNT_W-1:0] m_meas;
  bit               m_valid;
  bit               m_tout;
  bit               m_ovl;
  bit               m_stray;
  int               m_n;
  bit               m_pst;
  bit               m_psp;
  snap_t            q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t snap();
    snap_t s;
    s.busy  = m_open;
    s.meas  = m_meas;
    s.valid = m_valid;
    s.tout  = m_tout;
    s.ovl   = m_ovl;
    s.stray = m_stray;
    s.n     = NM_W'(m_n);
    return s;
  endfunction

  task automatic check_snap(input snap_t s);
    chk("busy",      64'(busy),      64'(s.busy));
    chk("meas",      64'(meas),      64'(s.meas));
    chk("valid",     64'(valid),     64'(s.valid));
    chk("tout",      64'(tout),      64'(s.tout));
    chk("err_ovl",   64'(err_ovl),   64'(s.ovl));
    chk("err_stray", 64'(err_stray), 64'(s.stray));
    chk("n_meas",    64'(n_meas),    64'(s.n));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_meas"},  64'(meas),      64'd0);
    chk({tag, "_valid"}, 64'(valid),     64'd0);
    chk({tag, "_tout"},  64'(tout),      64'd0);
    chk({tag, "_ovl"},   64'(err_ovl),   64'd0);
    chk({tag, "_stray"}, 64'(err_stray), 64'd0);
    chk({tag, "_n"},     64'(n_meas),    64'd0);
  endtask

  task automatic model_reset();
    m_open  = 1'b0;
    m_t     = 0;
    m_t0    = 0;
    m_meas  = '0;
    m_valid = 1'b0;
    m_tout  = 1'b0;
    m_ovl   = 1'b0;
    m_stray = 1'b0;
    m_n     = 0;
    m_pst   = 1'b0;
    m_psp   = 1'b0;
    q.delete();
    repeat (LAT) q.push_back(snap());
  endtask

  // Interval = difference of the start and stop edge timestamps.
  task automatic model_step(input bit st, input bit sp);
    bit st_e;
    bit sp_e;
    st_e    = st & ~m_pst;
    sp_e    = sp & ~m_psp;
    m_pst   = st;
    m_psp   = sp;
    m_valid = 1'b0;
    m_tout  = 1'b0;
    if (!m_open) begin
      if (st_e) begin
        m_open = 1'b1;
        m_t0   = m_t;
      end else if (sp_e) begin
        m_stray = 1'b1;
      end
    end else begin
      if (st_e) m_ovl = 1'b1;
      if (sp_e) begin
        m_meas  = CNT_W'(m_t - m_t0);
        m_valid = 1'b1;
        m_n     = m_n + 1;
        m_open  = 1'b0;
      end else if (m_t - m_t0 == TIMEOUT) begin
        m_tout = 1'b1;
        m_open = 1'b0;
      end
    end
    m_t++;
  endtask

  // One clock: check the output due now, then drive and model new inputs.
  // clr is only issued with no input edge in flight.
  task automatic cyc(input bit st, input bit sp, input bit cl);
    @(posedge clk_dlst);
    #1;
    check_snap(q.pop_front());
    start = st;
    stop  = sp;
    clr   = cl;
    model_step(st, sp);
    q.push_back(snap());
    if (cl) begin
      m_ovl   = 1'b0;
      m_stray = 1'b0;
      m_n     = 0;
      foreach (q[k]) begin
        q[k].ovl   = 1'b0;
        q[k].stray = 1'b0;
        q[k].n     = '0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int sp_div;
    int st_div;
    // Reset state
    #2;
    check_zero("rst");
    #21;
    rst = 1'b0;
    model_reset();
    idle(4);

    // 1: single pulse pair 100 cycles apart
    cyc(1'b1, 1'b0, 1'b0);
    idle(99);
    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    chk("t1_meas", 64'(meas), 64'd100);
    chk("t1_n", 64'(n_meas), 64'd1);
    chk("t1_flags", 64'({err_ovl, err_stray}), 64'd0);

    // 2: timeout, then stop exactly at the limit
    cyc(1'b1, 1'b0, 1'b0);
    idle(TIMEOUT + 8);
    chk("t2_meas_kept", 64'(meas), 64'd100);
    chk("t2_n_kept", 64'(n_meas), 64'd1);
    cyc(1'b1, 1'b0, 1'b0);
    idle(TIMEOUT - 1);
    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    chk("t2_meas_limit", 64'(meas), 64'(TIMEOUT));
    chk("t2_n_limit", 64'(n_meas), 64'd2);

    // 3: stray stop, clear, then coincident start+stop and stop at +7
    cyc(1'b0, 1'b1, 1'b0);
    idle(5);
    chk("t3_stray", 64'(err_stray), 64'd1);
    cyc(1'b0, 1'b0, 1'b1);
    idle(4);
    cyc(1'b1, 1'b1, 1'b0);
    idle(6);
    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    chk("t3_meas", 64'(meas), 64'd7);
    chk("t3_no_stray", 64'(err_stray), 64'd0);

    // 4: second start at +10, stop at +30, then clear
    cyc(1'b1, 1'b0, 1'b0);
    idle(9);
    cyc(1'b1, 1'b0, 1'b0);
    idle(19);
    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    chk("t4_ovl", 64'(err_ovl), 64'd1);
    chk("t4_meas", 64'(meas), 64'd30);
    cyc(1'b0, 1'b0, 1'b1);
    idle(4);
    chk("t4_clr_ovl", 64'(err_ovl), 64'd0);
    chk("t4_clr_n", 64'(n_meas), 64'd0);
    chk("t4_clr_meas", 64'(meas), 64'd30);

    // 5: levels held 20 cycles, stop rising 5 after start
    for (int k = 0; k < 25; k++) cyc(k < 20, k >= 5, 1'b0);
    idle(8);
    chk("t5_meas", 64'(meas), 64'd5);
    chk("t5_n", 64'(n_meas), 64'd1);

    // 6: asynchronous reset mid-measurement, then a spacing-3 pair
    cyc(1'b1, 1'b0, 1'b0);
    idle(42);
    #3;
    rst = 1'b1;
    #1;
    check_zero("t6_rst");
    start = 1'b0;
    stop  = 1'b0;
    clr   = 1'b0;
    #12;
    rst = 1'b0;
    model_reset();
    idle(10);
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    chk("t6_meas", 64'(meas), 64'd3);
    chk("t6_n", 64'(n_meas), 64'd1);

    // Random traffic: dense phases wrap n_meas, sparse-stop phases time out
    for (int p = 0; p < 6; p++) begin
      sp_div = (p % 2 == 1) ? 300 : 10;
      st_div = (p % 2 == 1) ? 60 : 25;
      for (int k = 0; k < 700; k++) begin
        cyc($urandom_range(st_div - 1, 0) == 0,
            $urandom_range(sp_div - 1, 0) == 0, 1'b0);
      end
    end
    idle(TIMEOUT + 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
